// File: rtl/minisys_hilo_pkg.sv
// Shared constants and control payload for the HI/LO multiply/divide unit.
package minisys_hilo_pkg;

    localparam int unsigned HILO_WIDTH = 32;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    // Operation flags captured when a mult/div is accepted.
    typedef struct packed {
        logic is_div;
        logic div_zero;
        logic neg_q;   // product / quotient must be negated
        logic neg_r;   // remainder (or div-by-zero dividend) must be negated
    } op_ctl_t;

endpackage

// File: rtl/hilo_iter_core.sv
// Radix-2 iterative datapath: shift-add multiply or restoring divide.
module hilo_iter_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a_mag,
    input  logic [WIDTH-1:0] b_mag,
    output logic [WIDTH-1:0] acc_hi,
    output logic [WIDTH-1:0] acc_lo
);

    logic [WIDTH-1:0] b_q;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    // One step of both algorithms; the sign bit of diff decides restore vs keep.
    always_comb begin
        add_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        shifted = {acc_hi, acc_lo[WIDTH-1]};
        diff    = shifted - {1'b0, b_q};
    end

    // Accumulator (HI half = partial product / remainder, LO half = multiplier / quotient).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_hi <= '0;
            acc_lo <= '0;
            b_q    <= '0;
        end else if (load) begin
            acc_hi <= '0;
            acc_lo <= a_mag;
            b_q    <= b_mag;
        end else if (step) begin
            if (is_div) begin
                acc_hi <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                acc_lo <= {acc_lo[WIDTH-2:0], ~diff[WIDTH]};
            end else begin
                acc_hi <= add_sum[WIDTH:1];
                acc_lo <= {add_sum[0], acc_lo[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO owner: iterative mult/div FSM, sign fix-up, mf/mt access and stall.
module hilo_muldiv_unit
    import minisys_hilo_pkg::*;
#(
    parameter int unsigned WIDTH = HILO_WIDTH,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [5:0]       Exe_opcode,
    input  logic [5:0]       Function_opcode,
    input  logic             Inst_valid,
    input  logic [WIDTH-1:0] Read_data_1,
    input  logic [WIDTH-1:0] Read_data_2,
    output logic [WIDTH-1:0] HI_result,
    output logic [WIDTH-1:0] LO_result,
    output logic [WIDTH-1:0] Hilo_read_data,
    output logic             Busy,
    output logic             Stall,
    output logic             Done,
    output logic             Div_by_zero
);

    localparam int unsigned PW = 2 * WIDTH;

    logic [1:0]       state, next_state;
    logic [CNT_W-1:0] cnt;
    op_ctl_t          ctl, ctl_new;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic [WIDTH-1:0] a_mag, b_mag, core_hi, core_lo, fix_hi, fix_lo;
    logic [PW-1:0]    prod;
    logic             special, req_md, req_mfhi, req_mflo, req_mthi, req_mtlo, req_any;
    logic             signed_op, a_neg, b_neg, load, step, done_q, dbz_q;

    // Instruction decode and operand magnitude / sign extraction.
    always_comb begin
        special   = Inst_valid && (Exe_opcode == OP_SPECIAL);
        req_md    = special && ((Function_opcode == F_MULT) || (Function_opcode == F_MULTU) ||
                                (Function_opcode == F_DIV)  || (Function_opcode == F_DIVU));
        req_mfhi  = special && (Function_opcode == F_MFHI);
        req_mflo  = special && (Function_opcode == F_MFLO);
        req_mthi  = special && (Function_opcode == F_MTHI);
        req_mtlo  = special && (Function_opcode == F_MTLO);
        req_any   = req_md || req_mfhi || req_mflo || req_mthi || req_mtlo;
        signed_op = (Function_opcode == F_MULT) || (Function_opcode == F_DIV);
        a_neg     = signed_op && Read_data_1[WIDTH-1];
        b_neg     = signed_op && Read_data_2[WIDTH-1];
        a_mag     = a_neg ? (-Read_data_1) : Read_data_1;
        b_mag     = b_neg ? (-Read_data_2) : Read_data_2;
        ctl_new.is_div   = (Function_opcode == F_DIV) || (Function_opcode == F_DIVU);
        ctl_new.div_zero = ctl_new.is_div && (Read_data_2 == '0);
        ctl_new.neg_q    = a_neg ^ b_neg;
        ctl_new.neg_r    = a_neg;
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    // Next state and datapath controls.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            S_IDLE: if (req_md) begin
                load       = 1'b1;
                next_state = ctl_new.div_zero ? S_FIX : S_CALC;
            end
            S_CALC: begin
                step = 1'b1;
                if (cnt == '0) next_state = S_FIX;
            end
            S_FIX:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Iteration counter, captured op flags and the Done/Div_by_zero pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            ctl    <= '0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
        end else begin
            if (load) begin
                cnt <= CNT_W'(WIDTH - 1);
                ctl <= ctl_new;
            end else if (step && (cnt != '0)) begin
                cnt <= cnt - CNT_W'(1);
            end
            done_q <= (next_state == S_FIX);
            dbz_q  <= (next_state == S_FIX) && (load ? ctl_new.div_zero : ctl.div_zero);
        end
    end

    hilo_iter_core #(.WIDTH(WIDTH)) u_core (
        .clock  (clock),
        .reset  (reset),
        .load   (load),
        .step   (step),
        .is_div (ctl.is_div),
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .acc_hi (core_hi),
        .acc_lo (core_lo)
    );

    // Sign correction; a div-by-zero leaves the untouched dividend magnitude in core_lo.
    always_comb begin
        prod   = {core_hi, core_lo};
        fix_hi = core_hi;
        fix_lo = core_lo;
        if (!ctl.is_div) begin
            {fix_hi, fix_lo} = ctl.neg_q ? (-prod) : prod;
        end else if (ctl.div_zero) begin
            fix_lo = '1;
            fix_hi = ctl.neg_r ? (-core_lo) : core_lo;
        end else begin
            fix_lo = ctl.neg_q ? (-core_lo) : core_lo;
            fix_hi = ctl.neg_r ? (-core_hi) : core_hi;
        end
    end

    // Architectural HI/LO: written by FIX or by mthi/mtlo while idle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (state == S_FIX) begin
            hi_q <= fix_hi;
            lo_q <= fix_lo;
        end else if (state == S_IDLE) begin
            if (req_mthi) hi_q <= Read_data_1;
            if (req_mtlo) lo_q <= Read_data_1;
        end
    end

    // Output drive; the mf path and stall are zero-latency by design.
    always_comb begin
        HI_result      = hi_q;
        LO_result      = lo_q;
        Busy           = (state != S_IDLE);
        Stall          = Busy && req_any;
        Done           = done_q;
        Div_by_zero    = dbz_q;
        Hilo_read_data = req_mfhi ? hi_q : (req_mflo ? lo_q : '0);
    end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Multi-cycle multiply/divide unit that owns the architectural HI/LO registers.
- Executes mult, multu, div and divu iteratively, and serves mfhi, mflo, mthi and mtlo.
- Sits beside the ALU in the EX stage and is the producing and reading end of the HI/LO interface.
- Raises Stall to freeze PC/IFetch while a result is pending.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high; clears all state.
Exe_opcode  input  6  instruction[31:26]; unit acts only when 6'b000000.
Function_opcode  input  6  instruction[5:0].
Inst_valid  input  1  an instruction is present in EX this cycle.
Read_data_1  input  WIDTH  rs value; dividend, multiplicand, or mthi/mtlo source.
Read_data_2  input  WIDTH  rt value; divisor or multiplier.
HI_result  output  WIDTH  HI register.
LO_result  output  WIDTH  LO register.
Hilo_read_data  output  WIDTH  mfhi/mflo data, valid when Stall=0.
Busy  output  1  operation in progress.
Stall  output  1  hold PC and the EX instruction.
Done  output  1  one-cycle pulse in the cycle HI/LO are written by mult/div.
Div_by_zero  output  1  pulses together with Done when the divisor was 0.

Behaviour:
- Reset values: HI_result=0, LO_result=0, Busy=0, Stall=0, Done=0, Div_by_zero=0, state=IDLE.
- Reset mid-operation aborts the operation; HI/LO are not written with a partial result.
- Function codes:
  - mult 011000, multu 011001, div 011010, divu 011011.
  - mfhi 010000, mthi 010001, mflo 010010, mtlo 010011.
- A request is Inst_valid & Exe_opcode==0 & a listed funct.
- States: IDLE, CALC, FIX.
- IDLE, mult/div request:
  - Latch operand magnitudes (two's-complement absolute value for signed ops), the result-sign flags and the op type.
  - Set the counter to WIDTH-1 and go to CALC.
  - Divide with Read_data_2==0 goes straight to FIX with the div-by-zero flag set.
- CALC: one radix-2 step per cycle.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract.
  - At counter==0 go to FIX.
- FIX:
  - Apply sign correction. Product is negated when signs differ. Quotient sign = sign(a)^sign(b); remainder sign = sign(a).
  - Write HI/LO at the end of the cycle, assert Done, return to IDLE.
- Latency:
  - Request accepted at edge E0; Done is high in the cycle after E32; HI/LO are visible after E33.
  - Total 34 cycles. Div-by-zero takes 2 cycles.
- Div-by-zero result: LO=all ones, HI=dividend (unchanged sign), Div_by_zero=1 with Done.
- Signed overflow 0x80000000 / -1: LO=0x80000000, HI=0. This is the natural magnitude result and needs no trap.
- Busy = (state != IDLE).
- Stall = Busy & (any request this cycle). The held instruction re-presents each cycle and is accepted on the first cycle Busy=0.
- Requests while Busy are ignored apart from driving Stall.
- The mult/div that started the operation does not re-trigger: acceptance clears its own Stall because Busy is 0 in the accept cycle.
- mfhi/mflo: Hilo_read_data is combinational from HI or LO, with zero latency when idle. It reads the new value in the cycle after the FIX write.
- mthi/mtlo in IDLE: write Read_data_1 to HI or LO at the next edge. The other register is unchanged.
- Hilo_read_data is 0 when there is no mf request.
- Done and Div_by_zero are single-cycle pulses, never held.

Decomposition:
- Package minisys_hilo_pkg: the funct constants above, the state enum {IDLE, CALC, FIX}, and the WIDTH default.
- Sub-module hilo_iter_core holds the accumulator/remainder registers and the single-step shift-add/shift-subtract datapath, selected by an is_div input.
- The top level holds the FSM, counter, sign handling, HI/LO registers and the stall logic.

Test Plan:
- mult, rs=0xFFFFFFFD (-3), rt=5 -> Stall high 0 cycles after accept, Done at cycle 33, HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- multu, rs=rt=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 after 34 cycles; Div_by_zero=0.
- div, rs=-7, rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Also div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- divu, rs=7, rt=0 -> Done and Div_by_zero pulse 1 cycle after accept, LO=0xFFFFFFFF, HI=7.
- mflo held from the cycle after a multu 6*7 accept -> Stall=1 until Busy drops, then Hilo_read_data=42 with Stall=0. Also mthi 0x1234 while idle -> HI=0x1234 next edge, LO unchanged.
- Assert reset at cycle 10 of a mult -> HI=LO=0, Busy=0 and Done=0 immediately; a new mult after release completes normally.
